// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared phase and mode encodings for the axis profiler
package motion_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_P1   = 3'd1,
        PH_P2   = 3'd2,
        PH_P3   = 3'd3,
        PH_P4   = 3'd4
    } phase_e;

    typedef enum logic {
        MODE_VEL = 1'b0,
        MODE_POS = 1'b1
    } mode_e;

    localparam int STEP_CNT_W = 4;

endpackage

// File: rtl/axis_profiler_if.sv
// rtl/axis_profiler_if.sv - command/status bundle between a motion host and axis_profiler
interface axis_profiler_if #(
    parameter int POS_W = 16,
    parameter int VEL_W = 32
);
    logic                    tick;
    logic                    mode;
    logic                    setPosEn;
    logic signed [POS_W-1:0] setPosPos;
    logic [VEL_W-1:0]        accel;
    logic [VEL_W-1:0]        maxVel;
    logic signed [POS_W-1:0] limitLo;
    logic signed [POS_W-1:0] limitHi;
    logic signed [VEL_W-1:0] targetVel;
    logic signed [POS_W-1:0] targetPos;
    logic                    busy;
    logic                    inMotion;
    logic                    atTarget;
    logic                    limitHit;
    logic signed [POS_W-1:0] currentPosition;
    logic                    mDir;
    logic                    mStep;

    modport master (
        output tick, mode, setPosEn, setPosPos, accel, maxVel,
               limitLo, limitHi, targetVel, targetPos,
        input  busy, inMotion, atTarget, limitHit, currentPosition, mDir, mStep
    );

    modport slave (
        input  tick, mode, setPosEn, setPosPos, accel, maxVel,
               limitLo, limitHi, targetVel, targetPos,
        output busy, inMotion, atTarget, limitHit, currentPosition, mDir, mStep
    );
endinterface

// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - stretches a one-clock step trigger to STEP_W clocks
module step_pulse_gen
    import motion_pkg::*;
#(
    parameter int STEP_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic trig_i,
    output logic pulse_o
);
    logic [STEP_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (trig_i)
            cnt_d = STEP_CNT_W'(STEP_W);
        else if (cnt_q != '0)
            cnt_d = cnt_q - STEP_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign pulse_o = (cnt_q != '0);
endmodule

// File: rtl/axis_profiler.sv
// rtl/axis_profiler.sv - trapezoidal single-axis profiler with soft limits and step output
module axis_profiler
    import motion_pkg::*;
#(
    parameter int POS_W  = 16,
    parameter int FRAC_W = 32,
    parameter int VEL_W  = 32,
    parameter int STEP_W = 4
) (
    input logic           clk,
    input logic           rst,
    axis_profiler_if.slave bus
);
    localparam int D_W    = POS_W + FRAC_W;
    localparam int C_W    = D_W + 2;
    localparam int V2     = VEL_W + 2;
    localparam int PROD_W = 3 * VEL_W;
    localparam logic [D_W-1:0] STOP_MAX = {1'b0, {(D_W-1){1'b1}}};

    phase_e                  phase_q, phase_d;
    mode_e                   mode_q, mode_d;
    logic signed [D_W-1:0]   disp_q, disp_d;
    logic signed [VEL_W-1:0] vel_q, vel_d, acc_q, acc_d, tv_q, tv_d;
    logic [VEL_W-1:0]        n_q, n_d;
    logic [D_W-1:0]          stop_q, stop_d;
    logic signed [POS_W-1:0] ref_q, ref_d;
    logic                    mdir_q, mdir_d, limit_q, limit_d;
    logic                    step_trig;

    logic signed [POS_W-1:0] pos_c;
    logic signed [POS_W:0]   lo_p1;
    logic signed [C_W-1:0]   disp_c, stop_c, hi_c, lo_c, lo1_c, tgt_c, err_c, abs_c;
    logic signed [VEL_W-1:0] tv_c, acc_pos, acc_neg;
    logic signed [V2-1:0]    vel_v, amag_v, tv_v;
    logic [PROD_W-1:0]       prod_c;
    logic                    near_c, tv_pos, tv_neg;

    assign pos_c   = disp_q[D_W-1:FRAC_W];
    assign lo_p1   = (POS_W+1)'(bus.limitLo) + (POS_W+1)'(1);
    assign disp_c  = C_W'(disp_q);
    assign stop_c  = C_W'(stop_q);
    assign hi_c    = C_W'($signed({bus.limitHi, {FRAC_W{1'b0}}}));
    assign lo_c    = C_W'($signed({bus.limitLo, {FRAC_W{1'b0}}}));
    assign lo1_c   = C_W'($signed({lo_p1, {FRAC_W{1'b0}}}));
    assign tgt_c   = C_W'($signed({bus.targetPos, {FRAC_W{1'b0}}}));
    assign err_c   = tgt_c - disp_c;
    assign abs_c   = err_c[C_W-1] ? -err_c : err_c;
    assign near_c  = (abs_c <= stop_c);
    assign prod_c  = PROD_W'(bus.accel) * PROD_W'(n_q) * PROD_W'(n_q);
    assign acc_pos = $signed(bus.accel);
    assign acc_neg = -acc_pos;
    assign vel_v   = V2'(vel_q);
    assign amag_v  = $signed({2'b00, bus.accel});
    assign tv_v    = V2'(tv_c);
    assign tv_pos  = !tv_c[VEL_W-1] && (tv_c != '0);
    assign tv_neg  = tv_c[VEL_W-1];

    // Position mode cruises at +/-maxVel until the remaining distance fits the braking distance.
    always_comb begin
        tv_c = '0;
        if (mode_q == MODE_VEL)
            tv_c = bus.targetVel;
        else if (!near_c) begin
            if (bus.targetPos > pos_c)
                tv_c = bus.maxVel;
            else if (bus.targetPos < pos_c)
                tv_c = -bus.maxVel;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (bus.setPosEn)
            phase_d = PH_IDLE;
        else begin
            case (phase_q)
                PH_IDLE: if (bus.tick) phase_d = PH_P1;
                PH_P1:   phase_d = PH_P2;
                PH_P2:   phase_d = PH_P3;
                PH_P3:   phase_d = PH_P4;
                default: phase_d = PH_IDLE;
            endcase
        end
    end

    always_comb begin
        mode_d    = mode_q;
        disp_d    = disp_q;
        vel_d     = vel_q;
        acc_d     = acc_q;
        n_d       = n_q;
        stop_d    = stop_q;
        tv_d      = tv_q;
        ref_d     = ref_q;
        mdir_d    = mdir_q;
        limit_d   = limit_q;
        step_trig = 1'b0;
        if (bus.setPosEn) begin
            disp_d  = $signed({bus.setPosPos, {FRAC_W{1'b0}}});
            vel_d   = '0;
            acc_d   = '0;
            n_d     = '0;
            stop_d  = '0;
            tv_d    = '0;
            ref_d   = bus.setPosPos;
            limit_d = 1'b0;
        end else begin
            case (phase_q)
                PH_IDLE: if (bus.tick) mode_d = mode_e'(bus.mode);
                PH_P1:   stop_d = (prod_c > PROD_W'(STOP_MAX)) ? STOP_MAX : prod_c[D_W-1:0];
                PH_P2: begin
                    tv_d  = tv_c;
                    acc_d = '0;
                    if (vel_q == '0) begin
                        n_d = '0;
                        if (tv_pos && disp_c < hi_c) begin
                            acc_d = acc_pos;
                            n_d   = VEL_W'(1);
                        end else if (tv_neg && disp_c > lo1_c) begin
                            acc_d = acc_neg;
                            n_d   = VEL_W'(1);
                        end
                    end else if (!vel_q[VEL_W-1]) begin
                        // A limit-only brake is recorded; a brake toward the target is not.
                        if (!tv_pos || disp_c + stop_c >= hi_c) begin
                            acc_d = acc_neg;
                            n_d   = n_q - VEL_W'(1);
                            if (tv_pos) limit_d = 1'b1;
                        end else if (vel_v + amag_v <= tv_v) begin
                            acc_d = acc_pos;
                            n_d   = n_q + VEL_W'(1);
                        end
                    end else begin
                        if (!tv_neg || disp_c - stop_c <= lo_c) begin
                            acc_d = acc_pos;
                            n_d   = n_q - VEL_W'(1);
                            if (tv_neg) limit_d = 1'b1;
                        end else if (vel_v - amag_v >= tv_v) begin
                            acc_d = acc_neg;
                            n_d   = n_q + VEL_W'(1);
                        end
                    end
                end
                PH_P3: begin
                    vel_d  = vel_q + acc_q;
                    disp_d = disp_q + (D_W'(vel_q) <<< 1) + D_W'(acc_q);
                    mdir_d = !vel_d[VEL_W-1];
                end
                PH_P4: begin
                    step_trig = (pos_c != ref_q);
                    ref_d     = pos_c;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            mode_q  <= MODE_VEL;
            disp_q  <= '0;
            vel_q   <= '0;
            acc_q   <= '0;
            n_q     <= '0;
            stop_q  <= '0;
            tv_q    <= '0;
            ref_q   <= '0;
            mdir_q  <= 1'b1;
            limit_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            mode_q  <= mode_d;
            disp_q  <= disp_d;
            vel_q   <= vel_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            stop_q  <= stop_d;
            tv_q    <= tv_d;
            ref_q   <= ref_d;
            mdir_q  <= mdir_d;
            limit_q <= limit_d;
        end
    end

    step_pulse_gen #(.STEP_W(STEP_W)) u_step (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.setPosEn),
        .trig_i  (step_trig),
        .pulse_o (bus.mStep)
    );

    assign bus.busy            = (phase_q != PH_IDLE);
    assign bus.currentPosition = pos_c;
    assign bus.mDir            = mdir_q;
    assign bus.limitHit        = limit_q;
    assign bus.inMotion        = (vel_q != '0) || (tv_q != '0) || (n_q != '0);
    assign bus.atTarget        = (mode_q == MODE_POS) && (vel_q == '0) && (n_q == '0)
                                 && (pos_c == bus.targetPos);
endmodule

// File: doc/axis_profiler.md
AXIS_PROFILER -- requirements
Module: axis_profiler

Interface
REQ-001 Parameter POS_W, 16, integer step-position width (signed).
REQ-002 Parameter FRAC_W, 32, fractional displacement bits below the step position.
REQ-003 Parameter VEL_W, 32, signed velocity/acceleration width, s0.(VEL_W-1).
REQ-004 Parameter STEP_W, 4, mStep pulse length in clk cycles (1..15).
REQ-005 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 tick  in  1  sample strobe; starts one 4-phase update sequence.
REQ-007 mode  in  1  0 = velocity mode, 1 = position mode; sampled at each tick.
REQ-008 setPosEn  in  1  force position; setPosPos  in  POS_W  forced position.
REQ-009 accel  in  VEL_W  unsigned per-sample acceleration magnitude; maxVel  in  VEL_W  position-mode speed cap.
REQ-010 limitLo, limitHi  in  POS_W  signed soft limits, inclusive.
REQ-011 targetVel  in  VEL_W  signed velocity-mode target; targetPos  in  POS_W  signed position-mode target.
REQ-012 busy  out  1  phase sequence active; inMotion  out  1  velocity, target velocity or accelSamples non-zero.
REQ-013 atTarget  out  1  position mode, stopped at targetPos; limitHit  out  1  sticky soft-limit stop flag.
REQ-014 currentPosition  out  POS_W  integer part of displacement; mDir  out  1  1 = +/0 direction; mStep  out  1  step pulse.

Function
REQ-015 tick with busy=0 shall run phases P1..P4 on four consecutive clocks; tick during busy shall be ignored.
REQ-016 P1 shall compute stopDist = accel*accelSamples*accelSamples, saturated to the POS_W+FRAC_W signed maximum.
REQ-017 Velocity mode: effective target tv = targetVel. Position mode: tv = +maxVel if targetPos > currentPosition, -maxVel if less, else 0; tv shall be forced to 0 once |(targetPos<<FRAC_W) - disp| <= stopDist.
REQ-018 P2 at vel=0: tv>0 and disp<limitHi gives acc=+accel, n=1; tv<0 and disp>limitLo+1 gives acc=-accel, n=1; otherwise acc=0, n=0.
REQ-019 P2 at vel>0: tv<=0 or disp+stopDist>=limitHi gives acc=-accel, n-1; else vel+accel<=tv gives acc=+accel, n+1; else acc=0. Mirror rules apply at vel<0.
REQ-020 P2 shall set limitHit when deceleration is caused only by a limit condition.
REQ-021 P3: disp <= disp + 2*vel + acc (sign-extended); vel <= vel + acc; mDir <= (vel>=0).
REQ-022 P4: if disp integer part differs from the value saved at the previous P4, mStep shall go high for STEP_W clocks; mDir is therefore stable at least one clock before the rising edge.
REQ-023 atTarget shall be 1 when mode=1, vel=0, n=0 and currentPosition==targetPos; else 0.
REQ-024 setPosEn shall have priority over all phases: vel, acc, n, stopDist <= 0; disp <= {setPosPos, 0}; the step reference is updated without a step; limitHit is cleared; the active sequence is aborted.
REQ-025 A reversal of tv sign mid-motion shall decelerate to vel=0 before any step in the new direction.

Reset
REQ-026 rst shall clear disp, vel, acc, n, stopDist, phase counter, step reference, pulse counter and limitHit; outputs shall be busy=0, mStep=0, mDir=1, currentPosition=0, atTarget=0.
REQ-027 rst mid-sequence or mid-pulse shall terminate both within the same clock.

Structure
REQ-028 Phase encoding (IDLE, P1..P4) and mode constants shall live in the shared package motion_pkg.
REQ-029 Step pulse stretching shall be a sub-module step_pulse_gen (trigger in, STEP_W counter, pulse out).

Verification
REQ-030 rst for 2 clocks -> busy=0, mStep=0, mDir=1, currentPosition=0, limitHit=0.
REQ-031 mode=0, accel=2^22, targetVel=2^24, 6 ticks -> vel = 2^24 after the 4th P3 and then held; inMotion=1.
REQ-032 mode=1, accel=2^22, maxVel=2^26, targetPos=10 from 0 -> exactly 10 mStep pulses with mDir=1, then currentPosition=10 and atTarget=1.
REQ-033 mode=0, limitHi=5, targetVel=2^26 -> currentPosition never exceeds 5, final vel=0, limitHit=1.
REQ-034 targetVel changed from +2^24 to -2^24 mid-motion -> vel passes through 0; no step with mDir=0 occurs before vel<0.
REQ-035 setPosEn with setPosPos=-3 during P2 of a moving axis -> next clock vel=0, currentPosition=-3, busy=0, no mStep.
